// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dm_port_arbiter
//  Purpose  : Two-port access controller for a word-organised data RAM with
//             byte-lane write enables and a 1-cycle registered read.
//             Port 0 (pipeline MEM stage) has priority; port 1 (debug/loader)
//             is guaranteed access after MAX_WAIT consecutive refusals.
//             Stores become lane enables plus replicated write data; loads are
//             lane-extracted and sign/zero-extended on return.
//  Ports    : clk, rst                 - clock, async active-high reset
//             pN_req/we/size/uns/addr/wdata - request from port N (held to gnt)
//             pN_gnt                    - request consumed this cycle (comb.)
//             pN_rvalid/rdata           - load response, one cycle after gnt
//             pN_err                    - misaligned/illegal-size pulse
//             ram_ena/wea/addr/din      - RAM strobe, lanes, word addr, data
//             ram_dout                  - RAM read data (cycle after ram_ena)
//  Revision : 1.0 - initial release
// ============================================================================
module dm_port_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic              p0_uns,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic              p1_uns,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic              ram_ena,
  output logic [3:0]        ram_wea,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  localparam int              c_STARVE_W = $clog2(MAX_WAIT + 1);
  localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(MAX_WAIT);

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [c_STARVE_W-1:0] r_starve;
  logic                  w_p1_win;

  // Port 1 takes the slot when port 0 is idle or once it has waited too long.
  assign w_p1_win = p1_req && (!p0_req || (r_starve == c_STARVE_MAX));
  assign p1_gnt   = !rst && w_p1_win;
  assign p0_gnt   = !rst && p0_req && !w_p1_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (p1_req && !p1_gnt) begin
      if (r_starve != c_STARVE_MAX) begin
        r_starve <= r_starve + 1'b1;
      end
    end else begin
      r_starve <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Selected request and legality
  // --------------------------------------------------------------------------
  logic              w_any;
  logic              w_sel;      // 1 = port 1 owns this cycle
  logic              w_we;
  logic [1:0]        w_size;
  logic              w_uns;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic [1:0]        w_off;
  logic              w_legal;
  logic              w_acc;

  assign w_any   = p0_gnt || p1_gnt;
  assign w_sel   = p1_gnt;
  assign w_we    = w_sel ? p1_we    : p0_we;
  assign w_size  = w_sel ? p1_size  : p0_size;
  assign w_uns   = w_sel ? p1_uns   : p0_uns;
  assign w_addr  = w_sel ? p1_addr  : p0_addr;
  assign w_wdata = w_sel ? p1_wdata : p0_wdata;
  assign w_off   = w_addr[1:0];

  always_comb begin
    w_legal = 1'b0;
    case (w_size)
      2'b00:   w_legal = 1'b1;
      2'b01:   w_legal = !w_off[0];
      2'b10:   w_legal = (w_off == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal requests are consumed (granted) but never reach the RAM.
  assign w_acc = w_any && w_legal;

  // --------------------------------------------------------------------------
  // Store lane enables and replicated write data
  // --------------------------------------------------------------------------
  logic [3:0]        w_wea;
  logic [31:0]       w_din;
  logic [ADDR_W-3:0] r_addr_hold;
  logic [31:0]       r_din_hold;

  always_comb begin
    w_wea = 4'b0000;
    w_din = w_wdata;
    case (w_size)
      2'b00: begin
        w_wea = 4'b0001 << w_off;
        w_din = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_wea = w_off[1] ? 4'b1100 : 4'b0011;
        w_din = {2{w_wdata[15:0]}};
      end
      default: begin
        w_wea = 4'b1111;
        w_din = w_wdata;
      end
    endcase
  end

  assign ram_ena  = w_acc;
  assign ram_wea  = (w_acc && w_we) ? w_wea : 4'b0000;
  // Address and data keep their last driven value while the RAM is idle.
  assign ram_addr = w_acc ? w_addr[ADDR_W-1:2] : r_addr_hold;
  assign ram_din  = w_acc ? w_din : r_din_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_hold <= '0;
      r_din_hold  <= '0;
    end else if (w_acc) begin
      r_addr_hold <= w_addr[ADDR_W-1:2];
      r_din_hold  <= w_din;
    end
  end

  // --------------------------------------------------------------------------
  // One-entry response stage (aligned with the RAM read latency)
  // --------------------------------------------------------------------------
  logic       r_rsp_vld;
  logic       r_rsp_port;
  logic [1:0] r_rsp_size;
  logic [1:0] r_rsp_off;
  logic       r_rsp_uns;
  logic       r_err0;
  logic       r_err1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_vld  <= 1'b0;
      r_rsp_port <= 1'b0;
      r_rsp_size <= 2'b00;
      r_rsp_off  <= 2'b00;
      r_rsp_uns  <= 1'b0;
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
    end else begin
      r_rsp_vld  <= w_acc && !w_we;
      r_rsp_port <= w_sel;
      r_rsp_size <= w_size;
      r_rsp_off  <= w_off;
      r_rsp_uns  <= w_uns;
      r_err0     <= p0_gnt && !w_legal;
      r_err1     <= p1_gnt && !w_legal;
    end
  end

  // --------------------------------------------------------------------------
  // Load data extraction and extension
  // --------------------------------------------------------------------------
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  always_comb begin
    w_byte = ram_dout[7:0];
    case (r_rsp_off)
      2'b00:   w_byte = ram_dout[7:0];
      2'b01:   w_byte = ram_dout[15:8];
      2'b10:   w_byte = ram_dout[23:16];
      default: w_byte = ram_dout[31:24];
    endcase
  end

  assign w_half = r_rsp_off[1] ? ram_dout[31:16] : ram_dout[15:0];

  always_comb begin
    w_ext = ram_dout;
    case (r_rsp_size)
      2'b00:   w_ext = r_rsp_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ext = r_rsp_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ext = ram_dout;
    endcase
  end

  assign p0_rvalid = r_rsp_vld && !r_rsp_port;
  assign p1_rvalid = r_rsp_vld &&  r_rsp_port;
  assign p0_rdata  = p0_rvalid ? w_ext : 32'h0;
  assign p1_rdata  = p1_rvalid ? w_ext : 32'h0;
  assign p0_err    = r_err0;
  assign p1_err    = r_err1;

endmodule
`default_nettype wire
